// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade/PWM output stage.
`timescale 1ns/1ps
package led_pkg;

   localparam int unsigned LVL_W   = 8;
   localparam logic [7:0]  LVL_MAX = 8'hFF;
   localparam int unsigned LED_N   = 4;

   typedef enum logic [1:0] {
      CH_DARK   = 2'd0,
      CH_FADING = 2'd1,
      CH_FULL   = 2'd2
   } chan_state_e;

   // Counter width for a divisor: $clog2(div), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: brightness level with load/decay and registered PWM compare.
`timescale 1ns/1ps
module led_fade_chan
   import led_pkg::*;
#(
   parameter int unsigned DECAY_STEP = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             bit_in,
   input  logic             dec_tick,
   input  logic [LVL_W-1:0] pwm_cnt,
   output logic [LVL_W-1:0] lvl,
   output logic             pwm_out
);

   localparam int unsigned     SUB_W  = LVL_W + 1;
   localparam logic [SUB_W-1:0] STEP9 = SUB_W'(DECAY_STEP);

   chan_state_e      state, state_nxt;
   logic [LVL_W-1:0] lvl_nxt;
   logic [SUB_W-1:0] diff;

   // State and level registers
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state   <= CH_DARK;
         lvl     <= '0;
         pwm_out <= 1'b0;
      end else begin
         state   <= state_nxt;
         lvl     <= lvl_nxt;
         pwm_out <= (state == CH_FULL) | (pwm_cnt < lvl);
      end
   end

   // Next state / level: load beats decay; decay saturates at zero
   always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      diff      = {1'b0, lvl} - STEP9;
      if (bit_in) begin
         state_nxt = CH_FULL;
         lvl_nxt   = LVL_MAX;
      end else if (dec_tick) begin
         case (state)
            CH_FULL, CH_FADING: begin
               lvl_nxt   = diff[SUB_W-1] ? '0 : diff[LVL_W-1:0];
               state_nxt = (lvl_nxt == '0) ? CH_DARK : CH_FADING;
            end
            default: begin
               state_nxt = CH_DARK;
               lvl_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// Four-channel LED fade stage: shared prescalers and PWM counter, one fade channel per LED.
`timescale 1ns/1ps
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int unsigned PWM_DIV    = 195,
   parameter int unsigned DECAY_DIV  = 250000,
   parameter int unsigned DECAY_STEP = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [LED_N-1:0] led_in,
   output logic [LED_N-1:0] led_out
);

   localparam int unsigned PRE_W = cnt_width(PWM_DIV);
   localparam int unsigned DEC_W = cnt_width(DECAY_DIV);

   if (PWM_DIV < 1) begin : g_bad_pwm_div
      $fatal(1, "led_fade_pwm: PWM_DIV must be >= 1");
   end
   if (DECAY_DIV < 1) begin : g_bad_decay_div
      $fatal(1, "led_fade_pwm: DECAY_DIV must be >= 1");
   end
   if (DECAY_STEP < 1 || DECAY_STEP > 255) begin : g_bad_decay_step
      $fatal(1, "led_fade_pwm: DECAY_STEP must be in 1..255");
   end

   logic [PRE_W-1:0] pre_cnt;
   logic [DEC_W-1:0] dec_cnt;
   logic [LVL_W-1:0] pwm_cnt;
   logic             pwm_tick_c;
   logic             dec_tick_c;
   // Per-channel levels, kept as a debug tap
   logic [LVL_W-1:0] lvl_unused [LED_N];

   assign pwm_tick_c = (pre_cnt == PRE_W'(PWM_DIV - 1));
   assign dec_tick_c = (dec_cnt == DEC_W'(DECAY_DIV - 1));

   // Free-running prescalers and PWM ramp shared by all channels
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pre_cnt <= '0;
         dec_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         pre_cnt <= pwm_tick_c ? '0 : pre_cnt + PRE_W'(1);
         dec_cnt <= dec_tick_c ? '0 : dec_cnt + DEC_W'(1);
         if (pwm_tick_c) begin
            pwm_cnt <= pwm_cnt + LVL_W'(1);
         end
      end
   end

   for (genvar i = 0; i < LED_N; i++) begin : g_chan
      led_fade_chan #(
         .DECAY_STEP (DECAY_STEP)
      ) u_chan (
         .sys_clk  (sys_clk),
         .sys_rst  (sys_rst),
         .bit_in   (led_in[i]),
         .dec_tick (dec_tick_c),
         .pwm_cnt  (pwm_cnt),
         .lvl      (lvl_unused[i]),
         .pwm_out  (led_out[i])
      );
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench: three parameterisations share one stimulus and a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_led_fade_pwm;

   localparam int NI = 3;
   localparam int PD = 1;
   localparam int DD [NI] = '{4, 4, 300};
   localparam int ST [NI] = '{64, 100, 64};

   logic       sys_clk;
   logic       sys_rst;
   logic [3:0] led_in;
   logic [3:0] out_a, out_b, out_c;
   logic [3:0] dut_out [NI];

   led_fade_pwm #(.PWM_DIV(PD), .DECAY_DIV(4), .DECAY_STEP(64)) dut_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .led_in(led_in), .led_out(out_a));
   led_fade_pwm #(.PWM_DIV(PD), .DECAY_DIV(4), .DECAY_STEP(100)) dut_b (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .led_in(led_in), .led_out(out_b));
   led_fade_pwm #(.PWM_DIV(PD), .DECAY_DIV(300), .DECAY_STEP(64)) dut_c (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .led_in(led_in), .led_out(out_c));

   assign dut_out[0] = out_a;
   assign dut_out[1] = out_b;
   assign dut_out[2] = out_c;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Behavioural model: edge index since reset release drives the ticks and PWM ramp arithmetically
   int       e;
   int       m_lvl [NI][4];
   bit [3:0] m_out [NI];
   int       qa[$];
   int       qb[$];

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         e = 0;
         for (int k = 0; k < NI; k++) begin
            m_out[k] = '0;
            for (int c = 0; c < 4; c++) m_lvl[k][c] = 0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            bit dtick;
            int pwm;
            dtick = (e % DD[k]) == DD[k] - 1;
            pwm   = (e / PD) % 256;
            for (int c = 0; c < 4; c++) begin
               m_out[k][c] = (m_lvl[k][c] == 255) || (pwm < m_lvl[k][c]);
               if (led_in[c]) begin
                  m_lvl[k][c] = 255;
               end else if (dtick && m_lvl[k][c] != 0) begin
                  m_lvl[k][c] = (m_lvl[k][c] > ST[k]) ? m_lvl[k][c] - ST[k] : 0;
                  if (c == 0 && k == 0) qa.push_back(m_lvl[k][c]);
                  if (c == 0 && k == 1) qb.push_back(m_lvl[k][c]);
               end
            end
         end
         e++;
      end
   end

   // Every-cycle comparison of all three DUTs against the model
   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         for (int k = 0; k < NI; k++) chk($sformatf("cycle_out_dut%0d", k), int'(dut_out[k]), int'(m_out[k]));
      end
   end

   initial begin
      int cnt, cnt_hi;
      bit found;
      sys_rst = 1'b1;
      led_in  = 4'b0000;
      repeat (3) @(negedge sys_clk);
      chk("reset_out_a", int'(out_a), 0);
      sys_rst = 1'b0;
      repeat (4) @(negedge sys_clk);
      chk("post_reset_out_c", int'(out_c), 0);

      // Full on and two-clock latency
      led_in = 4'b0001;
      @(negedge sys_clk);
      chk("latency_edge1", int'(out_a[0]), 0);
      @(negedge sys_clk);
      chk("latency_edge2", int'(out_a[0]), 1);
      cnt = 0; cnt_hi = 0;
      repeat (512) begin
         @(negedge sys_clk);
         cnt    += int'(out_a[0]);
         cnt_hi += (out_a[3:1] != 3'b000) ? 1 : 0;
      end
      chk("solid_on_512", cnt, 512);
      chk("others_dark", cnt_hi, 0);

      // Fade sequences, step 64 and saturating step 100
      qa.delete(); qb.delete();
      led_in = 4'b0000;
      repeat (30) @(negedge sys_clk);
      chk("fade64_len", qa.size(), 4);
      if (qa.size() == 4) begin
         chk("fade64_0", qa[0], 191); chk("fade64_1", qa[1], 127);
         chk("fade64_2", qa[2], 63);  chk("fade64_3", qa[3], 0);
      end
      chk("sat100_len", qb.size(), 3);
      if (qb.size() == 3) begin
         chk("sat100_0", qb[0], 155); chk("sat100_1", qb[1], 55); chk("sat100_2", qb[2], 0);
      end
      chk("fade_dark_a", int'(out_a), 0);
      chk("fade_dark_b", int'(out_b), 0);

      // Duty over a 256-clock window at level 191 (slow-decay instance)
      found = 0;
      for (int i = 0; i < 700 && !found; i++) begin
         @(negedge sys_clk);
         if (e % 300 == 0 && m_lvl[2][0] == 191) found = 1;
      end
      chk("wait_lvl191", int'(found), 1);
      @(negedge sys_clk);
      cnt = 0;
      repeat (256) begin
         @(negedge sys_clk);
         cnt += int'(out_c[0]);
      end
      chk("duty_191", cnt, 191);

      // Reset mid-fade clears output at once and leaves no tail
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge sys_clk);
         if (m_out[2][0]) found = 1;
      end
      chk("wait_out_c_high", int'(found), 1);
      #2 sys_rst = 1'b1;
      #1 chk("async_reset_out_c", int'(out_c), 0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cnt = 0;
      repeat (300) begin
         @(negedge sys_clk);
         cnt += int'(out_c != 4'b0000);
      end
      chk("no_tail_after_reset", cnt, 0);

      // Re-trigger during fading on a dec_tick cycle
      led_in = 4'b0001;
      repeat (3) @(negedge sys_clk);
      led_in = 4'b0000;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge sys_clk);
         if (m_lvl[0][0] == 127 && e % 4 == 3) found = 1;
      end
      chk("wait_lvl127_tick", int'(found), 1);
      led_in = 4'b0001;
      @(negedge sys_clk);
      led_in = 4'b0000;
      chk("retrigger_model_lvl", m_lvl[0][0], 255);
      @(negedge sys_clk);
      chk("retrigger_out", int'(out_a[0]), 1);
      repeat (30) @(negedge sys_clk);

      // Flow pattern rotation
      for (int r = 0; r < 8; r++) begin
         led_in = 4'(1 << (r % 4));
         repeat (5) @(negedge sys_clk);
         chk($sformatf("flow_on_%0d", r), int'(out_a[r % 4]), 1);
         repeat (15) @(negedge sys_clk);
      end
      led_in = 4'b0000;
      repeat (40) @(negedge sys_clk);
      chk("flow_dark_a", int'(out_a), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
